// File: rtl/rtc_core_param.sv
// HH:MM:SS timekeeper on a single clock: prescaled 1 Hz tick, key-driven time set,
// 12/24-hour display decode and an alarm that times out after ALARM_SECS ticks.
module rtc_core_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ALARM_SECS = 60
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       set_mode,
  input  logic [1:0] key_n,
  input  logic       fmt_12h,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_ack,
  output logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_SECS);

  logic [PW-1:0] pre_cnt;
  logic [AW-1:0] alarm_cnt;
  logic [5:0]    sec_r;
  logic [1:0]    key_s1, key_s2, key_s3;
  logic [1:0]    key_inc;
  logic          adv;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hour_nxt;
  logic          alarm_trig;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      tick_1hz <= 1'b0;
    end else if (set_mode) begin
      pre_cnt  <= '0;
      tick_1hz <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt  <= '0;
      tick_1hz <= 1'b1;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
      tick_1hz <= 1'b0;
    end
  end

  // key_s3 holds the previous synchronised level, so a press yields one fall pulse.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_s3 <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign key_inc   = set_mode ? (key_s3 & ~key_s2) : 2'b00;
  assign adv       = tick_1hz & ~set_mode;
  assign sec_wrap  = (sec_r == 6'd59);
  assign min_wrap  = (min == 6'd59);
  assign hour_wrap = (hour == 5'd23);
  assign sec_nxt   = sec_wrap ? 6'd0 : sec_r + 6'd1;
  assign min_nxt   = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
  assign hour_nxt  = (sec_wrap && min_wrap) ? (hour_wrap ? 5'd0 : hour + 5'd1) : hour;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      sec_r <= '0;
      min   <= '0;
      hour  <= '0;
    end else if (set_mode) begin
      sec_r <= '0;
      if (key_inc[0]) min  <= min_wrap  ? 6'd0 : min + 6'd1;
      if (key_inc[1]) hour <= hour_wrap ? 5'd0 : hour + 5'd1;
    end else if (tick_1hz) begin
      sec_r <= sec_nxt;
      min   <= min_nxt;
      hour  <= hour_nxt;
    end
  end

  // Only a tick landing on hh:mm:00 can trigger; key-set time never does.
  assign alarm_trig = adv && alarm_en && sec_wrap &&
                      (min_nxt == alarm_min) && (hour_nxt == alarm_hour);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm_ack || !alarm_en) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm_trig) begin
      alarm     <= 1'b1;
      alarm_cnt <= ALARM_LOAD;
    end else if (alarm && adv) begin
      alarm_cnt <= alarm_cnt - 1'b1;
      if (alarm_cnt == AW'(1)) alarm <= 1'b0;
    end
  end

  assign sec = set_mode ? 6'd0 : sec_r;
  assign pm  = (hour >= 5'd12);

  always_comb begin
    disp_hour = hour;
    if (fmt_12h) begin
      if (hour == 5'd0)       disp_hour = 5'd12;
      else if (hour > 5'd12)  disp_hour = hour - 5'd12;
    end
  end

endmodule

// File: tb/tb_rtc_core_param.sv
// Bench for rtc_core_param (CLK_HZ=10, ALARM_SECS=5): directed sequences, a 12/24h
// decode table and randomized traffic, all checked against a seconds-of-day model.
module tb_rtc_core_param;

  localparam int CLK_HZ     = 10;
  localparam int ALARM_SECS = 5;

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic       set_mode;
  logic [1:0] key_n;
  logic       fmt_12h;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_ack;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] disp_hour;
  logic       pm;
  logic       alarm;

  rtc_core_param #(.CLK_HZ(CLK_HZ), .ALARM_SECS(ALARM_SECS)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .set_mode  (set_mode),
    .key_n     (key_n),
    .fmt_12h   (fmt_12h),
    .alarm_en  (alarm_en),
    .alarm_hour(alarm_hour),
    .alarm_min (alarm_min),
    .alarm_ack (alarm_ack),
    .tick_1hz  (tick_1hz),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .disp_hour (disp_hour),
    .pm        (pm),
    .alarm     (alarm)
  );

  // clock / watchdog
  always #5 clk_50MHz = ~clk_50MHz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: time as seconds-of-day, tick phase relative to an anchor edge
  int         m_t, m_e, m_anchor, m_rem;
  bit         m_tick, m_alarm;
  logic [1:0] m_prev_k;
  int         due0[$];
  int         due1[$];

  typedef struct {
    int hour;
    bit fmt;
    int disp;
    bit pm;
  } dec_vec_t;
  dec_vec_t dec_tab[9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_t = 0; m_e = 0; m_anchor = 0; m_rem = 0;
    m_tick = 1'b0; m_alarm = 1'b0; m_prev_k = 2'b00;
    due0.delete(); due1.delete();
  endtask

  task automatic model_edge();
    bit adv, trig;
    int h, mm, s;
    m_e++;
    adv = m_tick && !set_mode;
    if (adv) m_t = (m_t + 1) % 86400;
    if (set_mode) m_t = m_t - (m_t % 60);
    if (due0.size() > 0 && due0[0] == m_e) begin
      void'(due0.pop_front());
      if (set_mode) begin
        h = m_t / 3600; mm = (m_t / 60) % 60; s = m_t % 60;
        m_t = h * 3600 + ((mm + 1) % 60) * 60 + s;
      end
    end
    if (due1.size() > 0 && due1[0] == m_e) begin
      void'(due1.pop_front());
      if (set_mode) begin
        h = m_t / 3600; mm = (m_t / 60) % 60; s = m_t % 60;
        m_t = ((h + 1) % 24) * 3600 + mm * 60 + s;
      end
    end
    if (m_prev_k[0] && !key_n[0]) due0.push_back(m_e + 2);
    if (m_prev_k[1] && !key_n[1]) due1.push_back(m_e + 2);
    m_prev_k = key_n;
    trig = adv && alarm_en && (alarm_hour < 24) && (alarm_min < 60) &&
           (m_t == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
    if (alarm_ack || !alarm_en) m_alarm = 1'b0;
    else if (trig) begin
      m_alarm = 1'b1;
      m_rem   = ALARM_SECS;
    end else if (m_alarm && adv) begin
      m_rem--;
      if (m_rem == 0) m_alarm = 1'b0;
    end
    if (set_mode) begin
      m_anchor = m_e;
      m_tick   = 1'b0;
    end else m_tick = ((m_e - m_anchor) % CLK_HZ) == 0;
  endtask

  task automatic check_model();
    int h, mm, s, d;
    bit p;
    h  = m_t / 3600;
    mm = (m_t / 60) % 60;
    s  = set_mode ? 0 : m_t % 60;
    p  = (h >= 12);
    d  = fmt_12h ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
    n_chk++;
    if ({tick_1hz, hour, min, sec, disp_hour, pm, alarm} ===
        {m_tick, 5'(h), 6'(mm), 6'(s), 5'(d), p, m_alarm}) n_pass++;
    else
      $display("FAIL model e=%0d: got tick=%0d %0d:%0d:%0d disp=%0d pm=%0d alarm=%0d, expected tick=%0d %0d:%0d:%0d disp=%0d pm=%0d alarm=%0d",
               m_e, tick_1hz, hour, min, sec, disp_hour, pm, alarm,
               m_tick, h, mm, s, d, p, m_alarm);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_50MHz);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic press_key(input logic [1:0] mask, input int hold);
    key_n = ~mask;
    repeat (hold) step();
    key_n = 2'b11;
    repeat (3) step();
  endtask

  task automatic set_time(input int h, input int m);
    set_mode = 1'b1;
    step();
    for (int i = 0; i < 24 && (m_t / 3600) != h; i++) press_key(2'b10, 1);
    for (int i = 0; i < 60 && ((m_t / 60) % 60) != m; i++) press_key(2'b01, 1);
  endtask

  task automatic wait_ticks(input int n);
    int seen, budget;
    seen = 0;
    budget = n * CLK_HZ + 50;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (tick_1hz) seen++;
    end
    chk("wait_ticks", seen, n);
    step();
  endtask

  task automatic wait_alarm(input int budget);
    int b;
    b = budget;
    while (!alarm && b > 0) begin
      step();
      b--;
    end
    chk("alarm_rise", alarm, 1);
  endtask

  initial begin
    int n_ticks, last_e, cnt, seen_alarm, hold;
    logic [1:0] mask;

    dec_tab[0] = '{0, 1'b1, 12, 1'b0};
    dec_tab[1] = '{1, 1'b1, 1, 1'b0};
    dec_tab[2] = '{11, 1'b1, 11, 1'b0};
    dec_tab[3] = '{12, 1'b1, 12, 1'b1};
    dec_tab[4] = '{13, 1'b1, 1, 1'b1};
    dec_tab[5] = '{23, 1'b1, 11, 1'b1};
    dec_tab[6] = '{0, 1'b0, 0, 1'b0};
    dec_tab[7] = '{13, 1'b0, 13, 1'b1};
    dec_tab[8] = '{23, 1'b0, 23, 1'b1};

    rst = 1'b1; set_mode = 1'b0; key_n = 2'b11; fmt_12h = 1'b0;
    alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0; alarm_ack = 1'b0;
    model_reset();
    #2;
    check_model();
    fmt_12h = 1'b1;
    #1;
    chk("reset_disp_12h", disp_hour, 12);
    chk("reset_pm", pm, 0);
    fmt_12h = 1'b0;
    #9;
    rst = 1'b0;

    // 1: 60 evenly spaced ticks in 600 cycles
    n_ticks = 0; last_e = 0;
    repeat (601) begin
      step();
      if (tick_1hz) begin
        n_ticks++;
        chk("tick_spacing", m_e - last_e, CLK_HZ);
        last_e = m_e;
      end
    end
    chk("tick_count", n_ticks, 60);
    chk("t1_hour", hour, 0);
    chk("t1_min", min, 1);
    chk("t1_sec", sec, 0);

    // 2: rollover from 23:59:00
    set_time(23, 59);
    chk("t2_set_hour", hour, 23);
    chk("t2_set_min", min, 59);
    set_mode = 1'b0;
    wait_ticks(60);
    chk("t2_hour", hour, 0);
    chk("t2_min", min, 0);
    chk("t2_sec", sec, 0);
    chk("t2_pm", pm, 0);

    // 3: set-mode sec clear, held key, keys ignored outside set mode
    set_time(0, 58);
    set_mode = 1'b0;
    wait_ticks(17);
    chk("t3_sec17", sec, 17);
    set_mode = 1'b1;
    #1;
    chk("t3_sec_clear", sec, 0);
    press_key(2'b01, 1);
    press_key(2'b01, 50);
    press_key(2'b01, 3);
    chk("t3_min", min, 1);
    chk("t3_hour", hour, 0);
    set_mode = 1'b0;
    step();
    press_key(2'b01, 2);
    press_key(2'b10, 2);
    chk("t3_ignored_min", min, 1);
    chk("t3_ignored_hour", hour, 0);

    // 4: display decode table
    foreach (dec_tab[i]) begin
      set_time(dec_tab[i].hour, (m_t / 60) % 60);
      fmt_12h = dec_tab[i].fmt;
      step();
      chk($sformatf("dec_disp_h%0d_f%0d", dec_tab[i].hour, dec_tab[i].fmt), disp_hour, dec_tab[i].disp);
      chk($sformatf("dec_pm_h%0d", dec_tab[i].hour), pm, dec_tab[i].pm);
    end
    fmt_12h = 1'b0;

    // 5: alarm timeout, ack, unreachable hour
    set_time(0, 1);
    alarm_hour = 5'd0; alarm_min = 6'd2; alarm_en = 1'b1;
    set_mode = 1'b0;
    wait_alarm(800);
    chk("t5_rise_min", min, 2);
    chk("t5_rise_sec", sec, 0);
    cnt = 0;
    for (int b = 0; b < 100 && alarm; b++) begin
      step();
      if (alarm && tick_1hz) cnt++;
    end
    chk("t5_timeout_ticks", cnt, ALARM_SECS);
    chk("t5_fall_sec", sec, ALARM_SECS);
    set_time(0, 1);
    set_mode = 1'b0;
    wait_alarm(800);
    step();
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("t5_ack_clear", alarm, 0);
    set_time(0, 1);
    alarm_hour = 5'd24;
    set_mode = 1'b0;
    seen_alarm = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (alarm) seen_alarm = 1;
    end
    chk("t5_hour24_never", seen_alarm, 0);

    // 6: asynchronous reset with alarm active
    set_time(12, 33);
    alarm_hour = 5'd12; alarm_min = 6'd34;
    set_mode = 1'b0;
    wait_alarm(800);
    wait_ticks(3);
    chk("t6_pre_alarm", alarm, 1);
    chk("t6_pre_sec", sec, 3);
    #3;
    rst = 1'b1;
    fmt_12h = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("t6_rst_alarm", alarm, 0);
    chk("t6_rst_disp", disp_hour, 12);
    repeat (3) step();
    rst = 1'b0;
    alarm_en = 1'b0;
    fmt_12h = 1'b0;
    wait_ticks(3);
    chk("t6_restart_sec", sec, 3);
    chk("t6_restart_hour", hour, 0);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: begin
          cnt = $urandom_range(5, 60);
          repeat (cnt) begin
            alarm_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 7) == 0) fmt_12h = ~fmt_12h;
            step();
          end
          alarm_ack = 1'b0;
        end
        1: begin
          set_mode = 1'b1;
          repeat ($urandom_range(1, 4)) begin
            mask = 2'($urandom_range(1, 3));
            hold = $urandom_range(1, 5);
            press_key(mask, hold);
          end
          set_mode = 1'b0;
          step();
        end
        2: begin
          alarm_hour = ($urandom_range(0, 5) == 0) ? 5'd24 : 5'(m_t / 3600);
          alarm_min  = 6'(((m_t / 60) % 60 + 1) % 60);
          alarm_en   = 1'b1;
          repeat ((60 - m_t % 60) * CLK_HZ + 60) begin
            alarm_ack = ($urandom_range(0, 63) == 0);
            step();
          end
          alarm_ack = 1'b0;
        end
        default: begin
          mask = 2'($urandom_range(1, 3));
          press_key(mask, $urandom_range(1, 4));
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
